// File: rtl/sp_rx_align_if.sv
// Serial receive bus for sp_rx_align: one serial data line toward the
// aligner and the recovered symbol stream plus link status coming back.
// The master drives the serial line; the slave is the aligner itself.
interface sp_rx_align_if #(
  parameter int WIDTH = 8
);

  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             comma_out;
  logic             active;
  logic             lock_lost;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  comma_out,
    input  active,
    input  lock_lost
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output comma_out,
    output active,
    output lock_lost
  );

endinterface

// File: rtl/sp_rx_align.sv
// Serial symbol aligner. Bits arrive MSB first on data_in; a comma symbol
// found anywhere in the bit stream fixes the symbol phase. After LOCK_COUNT
// commas land on consecutive boundaries the link goes ACTIVE and delivers
// symbols. A comma that shows up off the boundary LOSS_LIMIT times in a row
// (with no aligned comma in between) drops the link back to SEARCH.
module sp_rx_align #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_LIMIT = 2
) (
  input logic          clk_32f,
  input logic          rst,
  sp_rx_align_if.slave bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_LIMIT + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] LOSS_LAST = MW'(LOSS_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ALIGN,
    ST_ACTIVE
  } state_t;

  state_t           state;
  logic [WIDTH-2:0] shift;
  logic [WIDTH-1:0] win;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_next;
  logic [CW-1:0]    comma_cnt;
  logic [MW-1:0]    miss_cnt;
  logic             is_comma;
  logic             boundary;

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             comma_q;
  logic             active_q;
  logic             lost_q;

  // The window includes the bit being sampled this edge, so a symbol is
  // recognised on the very edge that captures its LSB.
  assign win      = {shift, bus.data_in};
  assign is_comma = (win == COMMA);
  assign boundary = (bit_cnt == BIT_LAST);
  assign bit_next = boundary ? '0 : bit_cnt + BW'(1);

  // Serial history: shifts every cycle regardless of alignment state.
  always_ff @(posedge clk_32f or posedge rst) begin
    if (rst) begin
      shift <= '0;
    end else begin
      shift <= win[WIDTH-2:0];
    end
  end

  // Alignment FSM with symbol phase counter and registered outputs.
  always_ff @(posedge clk_32f or posedge rst) begin
    if (rst) begin
      state     <= ST_SEARCH;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      miss_cnt  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      comma_q   <= 1'b0;
      active_q  <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      bit_cnt <= bit_next;
      valid_q <= 1'b0;
      comma_q <= 1'b0;
      lost_q  <= 1'b0;

      case (state)
        ST_SEARCH: begin
          if (is_comma) begin
            bit_cnt  <= '0;
            miss_cnt <= '0;
            if (LOCK_COUNT == 1) begin
              state     <= ST_ACTIVE;
              active_q  <= 1'b1;
              comma_cnt <= '0;
            end else begin
              state     <= ST_ALIGN;
              comma_cnt <= CW'(1);
            end
          end
        end

        ST_ALIGN: begin
          if (boundary) begin
            if (is_comma) begin
              if (comma_cnt == LOCK_LAST) begin
                state     <= ST_ACTIVE;
                active_q  <= 1'b1;
                comma_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                comma_cnt <= comma_cnt + CW'(1);
              end
            end else begin
              state     <= ST_SEARCH;
              comma_cnt <= '0;
            end
          end
        end

        ST_ACTIVE: begin
          if (boundary) begin
            if (is_comma) begin
              comma_q  <= 1'b1;
              miss_cnt <= '0;
            end else begin
              data_q  <= win;
              valid_q <= 1'b1;
            end
          end else if (is_comma) begin
            if (miss_cnt == LOSS_LAST) begin
              state     <= ST_SEARCH;
              active_q  <= 1'b0;
              lost_q    <= 1'b1;
              miss_cnt  <= '0;
              comma_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + MW'(1);
            end
          end
        end

        default: begin
          state    <= ST_SEARCH;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.comma_out = comma_q;
  assign bus.active    = active_q;
  assign bus.lock_lost = lost_q;

endmodule

// File: tb/tb_sp_rx_align.sv
// Bench for sp_rx_align: two instances (8-bit default, 10-bit/2-comma),
// directed scenarios followed by random comma/data/bit-slip streams, all
// compared every cycle against a bit-level reference model.
module tb_sp_rx_align;

  localparam int M_SEARCH = 0;
  localparam int M_ALIGN  = 1;
  localparam int M_ACTIVE = 2;

  logic clk_32f;
  logic rst;

  sp_rx_align_if #(.WIDTH(8))  bus0();
  sp_rx_align_if #(.WIDTH(10)) bus1();

  sp_rx_align #(
    .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .LOSS_LIMIT(2)
  ) dut0 (
    .clk_32f(clk_32f), .rst(rst), .bus(bus0)
  );

  sp_rx_align #(
    .WIDTH(10), .COMMA(10'h0FA), .LOCK_COUNT(2), .LOSS_LIMIT(2)
  ) dut1 (
    .clk_32f(clk_32f), .rst(rst), .bus(bus1)
  );

  int check_count;
  int pass_count;

  int p_width [2] = '{8, 10};
  int p_comma [2] = '{'hBC, 'h0FA};
  int p_lock  [2] = '{4, 2};
  int p_loss  [2] = '{2, 2};

  int m_mode   [2];
  int m_cyc    [2];
  int m_anchor [2];
  int m_commas [2];
  int m_miss   [2];
  int m_hist   [2];

  int e_data   [2];
  bit e_valid  [2];
  bit e_comma  [2];
  bit e_active [2];
  bit e_lost   [2];

  bit q0[$];
  bit q1[$];

  // Free-running bit clock.
  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s at %0t: observed 0x%0h expected 0x%0h",
                  tag, $time, observed, expected);
  endtask

  // Returns both reference links to their power-on condition.
  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_SEARCH; m_cyc[k] = 0; m_anchor[k] = 0;
      m_commas[k] = 0; m_miss[k] = 0; m_hist[k] = 0;
      e_data[k] = 0; e_valid[k] = 0; e_comma[k] = 0;
      e_active[k] = 0; e_lost[k] = 0;
    end
  endfunction

  // Symbol phase is tracked as distance in bits from the comma that locked it.
  function automatic void modelStep(input int k, input bit b);
    int w;
    bit is_c;
    bit on_bnd;
    m_cyc[k]++;
    m_hist[k] = ((m_hist[k] << 1) | int'(b)) & ((1 << p_width[k]) - 1);
    w = m_hist[k];
    is_c = (w == p_comma[k]);
    on_bnd = ((m_cyc[k] - m_anchor[k]) % p_width[k]) == 0;
    e_valid[k] = 0; e_comma[k] = 0; e_lost[k] = 0;
    if (m_mode[k] == M_SEARCH) begin
      if (is_c) begin
        m_anchor[k] = m_cyc[k];
        m_miss[k] = 0;
        if (p_lock[k] == 1) m_mode[k] = M_ACTIVE;
        else begin m_mode[k] = M_ALIGN; m_commas[k] = 1; end
      end
    end else if (m_mode[k] == M_ALIGN) begin
      if (on_bnd) begin
        if (is_c) begin
          m_commas[k]++;
          if (m_commas[k] == p_lock[k]) begin m_mode[k] = M_ACTIVE; m_miss[k] = 0; end
        end else begin
          m_mode[k] = M_SEARCH; m_commas[k] = 0;
        end
      end
    end else begin
      if (on_bnd) begin
        if (is_c) begin e_comma[k] = 1; m_miss[k] = 0; end
        else begin e_data[k] = w; e_valid[k] = 1; end
      end else if (is_c) begin
        m_miss[k]++;
        if (m_miss[k] == p_loss[k]) begin
          m_mode[k] = M_SEARCH; e_lost[k] = 1; m_miss[k] = 0; m_commas[k] = 0;
        end
      end
    end
    e_active[k] = (m_mode[k] == M_ACTIVE);
  endfunction

  // Compares every output of both instances against the model.
  task automatic checkAll(input string where);
    checkOutput({where, " i0 data"},   32'(bus0.data_out),  e_data[0]);
    checkOutput({where, " i0 valid"},  32'(bus0.valid_out), 32'(e_valid[0]));
    checkOutput({where, " i0 comma"},  32'(bus0.comma_out), 32'(e_comma[0]));
    checkOutput({where, " i0 active"}, 32'(bus0.active),    32'(e_active[0]));
    checkOutput({where, " i0 lost"},   32'(bus0.lock_lost), 32'(e_lost[0]));
    checkOutput({where, " i1 data"},   32'(bus1.data_out),  e_data[1]);
    checkOutput({where, " i1 valid"},  32'(bus1.valid_out), 32'(e_valid[1]));
    checkOutput({where, " i1 comma"},  32'(bus1.comma_out), 32'(e_comma[1]));
    checkOutput({where, " i1 active"}, 32'(bus1.active),    32'(e_active[1]));
    checkOutput({where, " i1 lost"},   32'(bus1.lock_lost), 32'(e_lost[1]));
  endtask

  // One bit per instance for one clock, then a full comparison.
  task automatic applyStimulus(input bit b0, input bit b1);
    @(negedge clk_32f);
    bus0.data_in = b0;
    bus1.data_in = b1;
    @(posedge clk_32f);
    modelStep(0, b0);
    modelStep(1, b1);
    #1;
    checkAll("cycle");
  endtask

  // Sends a whole symbol MSB first to instance k; the other sees zeros.
  task automatic sendSym(input int k, input int val);
    int v;
    bit b;
    v = val;
    for (int i = p_width[k] - 1; i >= 0; i--) begin
      b = v[i];
      applyStimulus((k == 0) ? b : 1'b0, (k == 1) ? b : 1'b0);
    end
  endtask

  // Raises reset part-way through a bit period and checks it acts at once.
  task automatic applyReset(input bit b0, input bit b1);
    @(negedge clk_32f);
    bus0.data_in = b0;
    bus1.data_in = b1;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("async reset");
    @(posedge clk_32f);
    #1;
    checkAll("reset held");
    rst = 1'b0;
  endtask

  // Appends a random comma, data symbol or short bit slip for instance k.
  task automatic refill(input int k);
    int r;
    int v;
    int n;
    r = $urandom_range(0, 99);
    if (r < 93) begin
      v = (r < 45) ? p_comma[k] : int'($urandom) & ((1 << p_width[k]) - 1);
      for (int i = p_width[k] - 1; i >= 0; i--) begin
        if (k == 0) q0.push_back(v[i]); else q1.push_back(v[i]);
      end
    end else begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        if (k == 0) q0.push_back(1'($urandom)); else q1.push_back(1'($urandom));
      end
    end
  endtask

  initial begin
    bit b0;
    bit b1;
    check_count = 0;
    pass_count  = 0;
    rst = 1'b1;
    bus0.data_in = 1'b0;
    bus1.data_in = 1'b0;
    modelReset();

    @(posedge clk_32f);
    #1;
    checkAll("power-on reset");
    checkOutput("reset i0 data zero", 32'(bus0.data_out), 0);
    rst = 1'b0;

    $display("[TB] lock sequence F2 15 BC*4 DD 45");
    sendSym(0, 'hF2);
    sendSym(0, 'h15);
    for (int i = 0; i < 3; i++) sendSym(0, 'hBC);
    checkOutput("lock not before 4th comma", 32'(bus0.active), 0);
    sendSym(0, 'hBC);
    checkOutput("lock on 4th comma", 32'(bus0.active), 1);
    checkOutput("lock comma no valid", 32'(bus0.valid_out), 0);
    checkOutput("lock comma no comma_out", 32'(bus0.comma_out), 0);
    sendSym(0, 'hDD);
    checkOutput("DD valid", 32'(bus0.valid_out), 1);
    checkOutput("DD data", 32'(bus0.data_out), 'hDD);
    sendSym(0, 'h45);
    checkOutput("45 valid", 32'(bus0.valid_out), 1);
    checkOutput("45 data", 32'(bus0.data_out), 'h45);

    $display("[TB] active stream AA BC 13");
    sendSym(0, 'hAA);
    checkOutput("AA data", 32'(bus0.data_out), 'hAA);
    sendSym(0, 'hBC);
    checkOutput("aligned comma strobe", 32'(bus0.comma_out), 1);
    checkOutput("aligned comma holds data", 32'(bus0.data_out), 'hAA);
    checkOutput("aligned comma no valid", 32'(bus0.valid_out), 0);
    sendSym(0, 'h13);
    checkOutput("13 data", 32'(bus0.data_out), 'h13);

    $display("[TB] bit slip then two commas");
    applyStimulus(1'b0, 1'b0);
    sendSym(0, 'hBC);
    checkOutput("one misaligned keeps lock", 32'(bus0.active), 1);
    sendSym(0, 'hBC);
    checkOutput("lock_lost strobe", 32'(bus0.lock_lost), 1);
    checkOutput("active dropped", 32'(bus0.active), 0);
    sendSym(0, 'h00);
    checkOutput("lock_lost one cycle", 32'(bus0.lock_lost), 0);
    sendSym(0, 'h55);
    checkOutput("no valid after loss", 32'(bus0.valid_out), 0);

    $display("[TB] reset in the middle of an active symbol");
    for (int i = 0; i < 4; i++) sendSym(0, 'hBC);
    checkOutput("relock", 32'(bus0.active), 1);
    sendSym(0, 'h77);
    checkOutput("77 data", 32'(bus0.data_out), 'h77);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyReset(1'b0, 1'b0);
    checkOutput("reset clears data", 32'(bus0.data_out), 0);
    checkOutput("reset clears active", 32'(bus0.active), 0);
    sendSym(0, 'hDD);
    checkOutput("DD after reset no valid", 32'(bus0.valid_out), 0);
    for (int i = 0; i < 4; i++) sendSym(0, 'hBC);
    checkOutput("relock after reset", 32'(bus0.active), 1);

    $display("[TB] broken lock sequence BC*3 DD BC*4 AA");
    applyReset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) sendSym(0, 'hBC);
    sendSym(0, 'hDD);
    checkOutput("DD breaks alignment", 32'(bus0.active), 0);
    for (int i = 0; i < 3; i++) sendSym(0, 'hBC);
    checkOutput("three commas not enough", 32'(bus0.active), 0);
    sendSym(0, 'hBC);
    checkOutput("fresh four commas lock", 32'(bus0.active), 1);
    sendSym(0, 'hAA);
    checkOutput("AA valid after relock", 32'(bus0.valid_out), 1);
    checkOutput("AA data after relock", 32'(bus0.data_out), 'hAA);

    $display("[TB] 10-bit instance 0FA 0FA 2A5");
    sendSym(1, 'h0FA);
    checkOutput("w10 one comma", 32'(bus1.active), 0);
    sendSym(1, 'h0FA);
    checkOutput("w10 lock", 32'(bus1.active), 1);
    sendSym(1, 'h2A5);
    checkOutput("w10 valid", 32'(bus1.valid_out), 1);
    checkOutput("w10 data", 32'(bus1.data_out), 'h2A5);

    $display("[TB] random streams");
    for (int c = 0; c < 2500; c++) begin
      if (q0.size() == 0) refill(0);
      if (q1.size() == 0) refill(1);
      b0 = q0.pop_front();
      b1 = q1.pop_front();
      if (c == 1300) applyReset(b0, b1);
      else applyStimulus(b0, b1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
